// File: rtl/spram_stream_reader.sv
// spram_stream_reader
// Read-side controller for a single-port RAM with a one-cycle registered read.
// A start command streams num_words words from base_addr upward (wrapping
// modulo NUM_WORDS) onto a valid/ready stream, then pulses done for one cycle.
// Reads are issued against a two-entry output FIFO using a credit rule, so
// the stream runs at one word per cycle when the consumer is always ready and
// holds its data stable while stalled.
module spram_stream_reader #(
    parameter int AWIDTH    = 10,
    parameter int NUM_WORDS = 1024,
    parameter int DWIDTH    = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH:0]   num_words,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] mem_address,
    output logic              mem_wren,
    output logic [DWIDTH-1:0] mem_data,
    input  logic [DWIDTH-1:0] mem_out,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [AWIDTH-1:0] ADDR_ONE = AWIDTH'(1);
    localparam logic [AWIDTH-1:0] ADDR_MAX = AWIDTH'(NUM_WORDS - 1);
    localparam logic [AWIDTH:0]   CNT_ONE  = (AWIDTH + 1)'(1);

    state_t            state_q;
    state_t            state_d;
    logic [AWIDTH-1:0] addr_q;
    logic [AWIDTH-1:0] last_addr_q;
    logic [AWIDTH-1:0] addr_next;
    logic [AWIDTH:0]   num_q;
    logic [AWIDTH:0]   issued_q;
    logic [AWIDTH:0]   xfer_q;
    logic              inflight_q;
    logic [DWIDTH-1:0] fifo_mem [2];
    logic              rd_ptr_q;
    logic              wr_ptr_q;
    logic [1:0]        fifo_count_q;
    logic [2:0]        credit;
    logic              accept;
    logic              issue;
    logic              push;
    logic              pop;

    // The reader never writes the RAM.
    assign mem_wren = 1'b0;
    assign mem_data = '0;

    // Stream side is the head of the output FIFO; last is judged by words already transferred.
    assign out_valid = (fifo_count_q != 2'd0);
    assign out_data  = fifo_mem[rd_ptr_q];
    assign out_last  = out_valid && (xfer_q == (num_q - CNT_ONE));
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == FIN);

    // Handshake and credit: a slot being popped this cycle is free again, which keeps full throughput.
    always_comb begin
        accept    = (state_q == IDLE) && start;
        pop       = out_valid && out_ready;
        push      = inflight_q;
        credit    = {1'b0, fifo_count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = (state_q == RUN) && (credit < 3'd2);
        addr_next = (addr_q == ADDR_MAX) ? '0 : (addr_q + ADDR_ONE);
        // The address only moves on an issue; otherwise the last issued address is held.
        mem_address = issue ? addr_q : last_addr_q;
    end

    // Next-state logic for the command sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_words == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (issue && ((issued_q + CNT_ONE) == num_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command capture, read issue address and the issued/transferred word counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q      <= '0;
            last_addr_q <= '0;
            num_q       <= '0;
            issued_q    <= '0;
            xfer_q      <= '0;
            inflight_q  <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (accept) begin
                addr_q   <= base_addr;
                num_q    <= num_words;
                issued_q <= '0;
                xfer_q   <= '0;
            end else begin
                if (issue) begin
                    addr_q      <= addr_next;
                    last_addr_q <= addr_q;
                    issued_q    <= issued_q + CNT_ONE;
                end
                if (pop) begin
                    xfer_q <= xfer_q + CNT_ONE;
                end
            end
        end
    end

    // Two-entry output FIFO: RAM data lands here the cycle after its read was issued.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fifo_mem[0]  <= '0;
            fifo_mem[1]  <= '0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            fifo_count_q <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= mem_out;
                wr_ptr_q           <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   fifo_count_q <= fifo_count_q + 2'd1;
                2'b01:   fifo_count_q <= fifo_count_q - 2'd1;
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_spram_stream_reader.sv
// tb_spram_stream_reader
// Self-checking bench: a behavioural RAM feeds the reader, and a scoreboard
// queue built from the RAM contents (word k of a command is ram[(base+k) mod N])
// checks every stream transfer, the last flag, stall hold and done timing.
module tb_spram_stream_reader;

    localparam int AWIDTH    = 10;
    localparam int NUM_WORDS = 1024;
    localparam int DWIDTH    = 32;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic [AWIDTH-1:0] base_addr = '0;
    logic [AWIDTH:0]   num_words = '0;
    logic              busy;
    logic              done;
    logic [AWIDTH-1:0] mem_address;
    logic              mem_wren;
    logic [DWIDTH-1:0] mem_data;
    logic [DWIDTH-1:0] mem_out = '0;
    logic [DWIDTH-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              out_last;

    typedef struct {
        logic [DWIDTH-1:0] data;
        logic              last;
    } word_t;

    logic [DWIDTH-1:0] ram [NUM_WORDS];
    word_t             expQ [$];
    int                assertCount = 0;
    int                failCount = 0;
    int                doneSeen = 0;
    int                readyMode = 0;
    bit                wrenSeen = 1'b0;
    bit                memDataSeen = 1'b0;
    bit                prevStall = 1'b0;
    logic [DWIDTH-1:0] prevData = '0;
    logic              prevLast = 1'b0;

    spram_stream_reader #(
        .AWIDTH   (AWIDTH),
        .NUM_WORDS(NUM_WORDS),
        .DWIDTH   (DWIDTH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .base_addr  (base_addr),
        .num_words  (num_words),
        .busy       (busy),
        .done       (done),
        .mem_address(mem_address),
        .mem_wren   (mem_wren),
        .mem_data   (mem_data),
        .mem_out    (mem_out),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    // Single-port RAM with a one-cycle registered read.
    always @(posedge clk) begin
        mem_out <= ram[mem_address];
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Queue the expected words (if the command should be accepted) and pulse start for one cycle.
    task automatic applyStimulus(input int base, input int num, input bit expectAccept);
        word_t w;
        if (expectAccept) begin
            for (int k = 0; k < num; k++) begin
                w.data = ram[(base + k) % NUM_WORDS];
                w.last = (k == num - 1);
                expQ.push_back(w);
            end
        end
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = AWIDTH'(base);
        num_words = (AWIDTH + 1)'(num);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int maxCycles, input string tag);
        int n;
        n = 0;
        while (n < maxCycles) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        checkOutput({tag, "_done"}, done, 1);
        checkOutput({tag, "_queue_empty"}, expQ.size(), 0);
    endtask

    // Ready pattern generator: 0 = always ready, 1 = random, 2 = never ready.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard and stall-hold monitor, sampled mid-cycle.
    initial begin
        word_t w;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prevStall = 1'b0;
            end else begin
                if (mem_wren) wrenSeen = 1'b1;
                if (mem_data != '0) memDataSeen = 1'b1;
                if (done) doneSeen++;
                if (prevStall) begin
                    checkOutput("hold_valid", out_valid, 1);
                    checkOutput("hold_data", out_data, prevData);
                    checkOutput("hold_last", out_last, prevLast);
                end
                if (out_valid && out_ready) begin
                    checkOutput("xfer_expected", expQ.size() > 0, 1);
                    if (expQ.size() > 0) begin
                        w = expQ.pop_front();
                        checkOutput("xfer_data", out_data, w.data);
                        checkOutput("xfer_last", out_last, w.last);
                    end
                end
                prevStall = out_valid && !out_ready;
                prevData  = out_data;
                prevLast  = out_last;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", failCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int doneBefore;
        int base;
        int num;

        for (int i = 0; i < NUM_WORDS; i++) ram[i] = DWIDTH'(i);

        // Reset values
        #2;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_last", out_last, 0);
        checkOutput("rst_data", out_data, 0);
        checkOutput("rst_addr", mem_address, 0);
        repeat (3) @(posedge clk);
        #3 resetn = 1'b1;

        // Test 1: base 5, 4 words, always ready, exact cycle timing
        $display("[TB] test 1: basic stream timing");
        readyMode = 0;
        repeat (2) @(posedge clk);
        applyStimulus(5, 4, 1);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checkOutput($sformatf("t1_valid_c%0d", c), out_valid, (c >= 3 && c <= 6));
            checkOutput($sformatf("t1_busy_c%0d", c), busy, (c <= 6));
            checkOutput($sformatf("t1_done_c%0d", c), done, (c == 7));
            if (c >= 3 && c <= 6) begin
                checkOutput($sformatf("t1_data_c%0d", c), out_data, 5 + c - 3);
                checkOutput($sformatf("t1_last_c%0d", c), out_last, (c == 6));
            end
        end
        checkOutput("t1_queue_empty", expQ.size(), 0);

        // Test 2: address wrap
        $display("[TB] test 2: address wrap");
        applyStimulus(1022, 4, 1);
        waitDone(50, "t2");

        // Test 3: random backpressure
        $display("[TB] test 3: random backpressure");
        readyMode = 1;
        applyStimulus(int'($urandom_range(0, NUM_WORDS - 1)), 8, 1);
        waitDone(200, "t3");
        readyMode = 0;
        repeat (2) @(posedge clk);

        // Test 4: zero-length command
        $display("[TB] test 4: zero words");
        doneBefore = doneSeen;
        applyStimulus(7, 0, 1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("t4_valid_c%0d", c), out_valid, 0);
            checkOutput($sformatf("t4_busy_c%0d", c), busy, 0);
            checkOutput($sformatf("t4_done_c%0d", c), done, (c == 1));
        end

        // Test 5: start while busy is ignored
        $display("[TB] test 5: start while busy");
        doneBefore = doneSeen;
        applyStimulus(10, 6, 1);
        applyStimulus(100, 3, 0);
        waitDone(100, "t5");
        repeat (10) @(posedge clk);
        #1;
        checkOutput("t5_idle_after", busy, 0);
        checkOutput("t5_done_count", doneSeen - doneBefore, 1);

        // Test 6: reset mid-command abandons it
        $display("[TB] test 6: reset mid-command");
        readyMode = 2;
        repeat (2) @(posedge clk);
        applyStimulus(200, 3, 1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        checkOutput("t6_valid_before", out_valid, 1);
        checkOutput("t6_busy_before", busy, 1);
        doneBefore = doneSeen;
        @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        checkOutput("t6_valid_rst", out_valid, 0);
        checkOutput("t6_busy_rst", busy, 0);
        checkOutput("t6_done_rst", done, 0);
        checkOutput("t6_last_rst", out_last, 0);
        checkOutput("t6_data_rst", out_data, 0);
        checkOutput("t6_addr_rst", mem_address, 0);
        expQ.delete();
        readyMode = 0;
        repeat (3) @(posedge clk);
        #3 resetn = 1'b1;
        applyStimulus(0, 2, 1);
        waitDone(50, "t6");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t6_done_count", doneSeen - doneBefore, 1);

        // Random commands over random RAM contents, including a full-depth read
        $display("[TB] random commands");
        for (int i = 0; i < NUM_WORDS; i++) ram[i] = $urandom;
        for (int n = 0; n < 12; n++) begin
            readyMode = int'($urandom_range(0, 1));
            base = int'($urandom_range(0, NUM_WORDS - 1));
            num  = (n == 11) ? NUM_WORDS : int'($urandom_range(1, 40));
            applyStimulus(base, num, 1);
            waitDone(8 * num + 50, $sformatf("rnd%0d", n));
            readyMode = 0;
            repeat (2) @(posedge clk);
        end

        checkOutput("wren_never", wrenSeen, 0);
        checkOutput("mem_data_zero", memDataSeen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
